// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by uart_tx and uart_rx: data width, the FSM state
// encoding, the baud divisor calculation, parameter legality and the parity
// helper. Keeping these here means a loopback of the two blocks uses the same
// bit timing.
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned DATA_W = 32'd8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Clock cycles per bit, truncating integer divide.
    function automatic int unsigned clks_per_bit(input int unsigned clock_freq,
                                                 input int unsigned baud_rate);
        return clock_freq / baud_rate;
    endfunction

    // A bit must last at least two clocks, and only one or two stop bits exist.
    function automatic bit params_ok(input int unsigned cpb,
                                     input int unsigned stop_bits);
        return (cpb >= 32'd2) && ((stop_bits == 32'd1) || (stop_bits == 32'd2));
    endfunction

    // Parity bit to append: even parity is the XOR of the data, odd inverts it.
    function automatic logic parity_bit(input logic [DATA_W-1:0] data,
                                        input logic              odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Restartable bit-period counter. Counts 0..CLKS_PER_BIT-1 and wraps; the tick
// marks the last cycle of each bit period. While clear_i is high the count is
// held at zero so the first period after clear_i falls is a full bit long.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   clear_i      hold the counter at zero
//   baud_tick_o  high in the last cycle of each bit period
// -----------------------------------------------------------------------------
module uart_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 32'd8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    output logic baud_tick_o
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 32'd1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign baud_tick_o = (cnt_q == CNT_LAST);

    // Next count: clear, wrap at the terminal count, or increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || baud_tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// UART transmitter. Accepts one byte per valid/ready handshake and sends it
// LSB first as start, 8 data bits, optional parity and one or two stop bits.
//
// Ports:
//   clk       system clock
//   rst_n     synchronous active-low reset
//   tx_data   byte to send, captured on the handshake edge
//   tx_valid  tx_data is valid
//   tx_ready  block can accept a byte this cycle (combinational)
//   tx        serial line, idle high (registered)
//   tx_busy   frame in progress (registered)
//   tx_done   one-cycle pulse when the frame completes (registered)
// -----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 32'd50000000,
    parameter int unsigned BAUD_RATE  = 32'd9600,
    parameter int unsigned PARITY_EN  = 32'd0,
    parameter int unsigned PARITY_ODD = 32'd0,
    parameter int unsigned STOP_BITS  = 32'd1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
    localparam logic        LAST_STOP    = 1'(STOP_BITS - 32'd1);

    if (!params_ok(CLKS_PER_BIT, STOP_BITS)) begin : g_param_err
        $error("uart_tx: CLKS_PER_BIT must be >= 2 and STOP_BITS must be 1 or 2");
    end

    uart_state_e       state_q,    state_d;
    logic [DATA_W-1:0] shreg_q,    shreg_d;
    logic [2:0]        bit_idx_q,  bit_idx_d;
    logic              stop_cnt_q, stop_cnt_d;
    logic              tx_q,       tx_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
    logic              accept_s;
    logic              baud_tick_s;
    logic              baud_clear_s;

    // The bit counter idles at zero, so it restarts cleanly on acceptance.
    assign baud_clear_s = (state_q == ST_IDLE);

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (baud_clear_s),
        .baud_tick_o (baud_tick_s)
    );

    assign tx_ready = (state_q == ST_IDLE) && rst_n;
    assign accept_s = tx_valid && tx_ready;
    assign tx       = tx_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

    // Next-state and registered-output values; tx_d is the line level for the
    // bit that starts at the coming edge.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (accept_s) begin
                    state_d    = ST_START;
                    shreg_d    = tx_data;
                    bit_idx_d  = 3'd0;
                    stop_cnt_d = 1'b0;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_tick_s) begin
                    state_d = ST_DATA;
                    tx_d    = shreg_q[0];
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (baud_tick_s) begin
                    if (bit_idx_q == 3'd7) begin
                        if (PARITY_EN != 32'd0) begin
                            state_d = ST_PARITY;
                            tx_d    = parity_bit(shreg_q, PARITY_ODD != 32'd0);
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shreg_q[bit_idx_q + 3'd1];
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (baud_tick_s) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                tx_d = 1'b1;
                if (baud_tick_s) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            bit_idx_q  <= 3'd0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Four transmitters at 8 clocks per bit: 0 = no parity / 1 stop,
// 1 = even parity, 2 = odd parity, 3 = even parity with 2 stop bits.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    logic       clk;
    logic       rst_n;
    logic [3:0] valid_s;
    logic [3:0] ready_s;
    logic [3:0] tx_s;
    logic [3:0] busy_s;
    logic [3:0] done_s;
    logic [7:0] data_s [4];

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int         dut;
        logic [7:0] data;
        bit         par_en;
        logic       par_bit;
        int         len;
    } vec_t;

    vec_t vecs [8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx #(.CLOCK_FREQ(800), .BAUD_RATE(100), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .tx_data(data_s[0]), .tx_valid(valid_s[0]),
        .tx_ready(ready_s[0]), .tx(tx_s[0]), .tx_busy(busy_s[0]), .tx_done(done_s[0]));
    uart_tx #(.CLOCK_FREQ(800), .BAUD_RATE(100), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .tx_data(data_s[1]), .tx_valid(valid_s[1]),
        .tx_ready(ready_s[1]), .tx(tx_s[1]), .tx_busy(busy_s[1]), .tx_done(done_s[1]));
    uart_tx #(.CLOCK_FREQ(800), .BAUD_RATE(100), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .tx_data(data_s[2]), .tx_valid(valid_s[2]),
        .tx_ready(ready_s[2]), .tx(tx_s[2]), .tx_busy(busy_s[2]), .tx_done(done_s[2]));
    uart_tx #(.CLOCK_FREQ(800), .BAUD_RATE(100), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .tx_data(data_s[3]), .tx_valid(valid_s[3]),
        .tx_ready(ready_s[3]), .tx(tx_s[3]), .tx_busy(busy_s[3]), .tx_done(done_s[3]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called 1ns after the acceptance edge. Compares the line against the
    // expected level every cycle for len cycles (one check per bit slot), then
    // checks the completion edge. Returns 1ns after the completion edge.
    task automatic run_frame(input int d, input logic [7:0] b, input bit par_en,
                             input logic par_bit, input int len, input string tag);
        logic lvl;
        logic obs;
        logic ctrl_bad;
        logic early_done;
        int   s;
        obs        = 1'b0;
        ctrl_bad   = 1'b0;
        early_done = 1'b0;
        for (int k = 0; k < len; k++) begin
            s = k / 8;
            if (s == 0)                  lvl = 1'b0;
            else if (s <= 8)             lvl = b[s-1];
            else if (par_en && s == 9)   lvl = par_bit;
            else                         lvl = 1'b1;
            if (k % 8 == 0) obs = lvl;
            if (tx_s[d] !== lvl) obs = tx_s[d];
            if (busy_s[d] !== 1'b1 || ready_s[d] !== 1'b0) ctrl_bad = 1'b1;
            if (done_s[d] !== 1'b0) early_done = 1'b1;
            if (k % 8 == 7) check($sformatf("%s slot%0d level", tag, s), 32'(obs), 32'(lvl));
            if (k < len - 1) step();
        end
        step();
        check({tag, " busy/ready during frame"}, 32'(ctrl_bad), 32'd0);
        check({tag, " no early done"}, 32'(early_done), 32'd0);
        check({tag, " done at frame end"}, 32'(done_s[d]), 32'd1);
        check({tag, " busy low at end"}, 32'(busy_s[d]), 32'd0);
        check({tag, " ready at end"}, 32'(ready_s[d]), 32'd1);
        check({tag, " line idle at end"}, 32'(tx_s[d]), 32'd1);
    endtask

    // Handshake one byte, corrupt tx_data right after, check the frame and
    // that tx_done drops after one cycle.
    task automatic send(input int d, input logic [7:0] b, input bit par_en,
                        input logic par_bit, input int len, input string tag);
        check({tag, " ready before send"}, 32'(ready_s[d]), 32'd1);
        valid_s[d] = 1'b1;
        data_s[d]  = b;
        step();
        valid_s[d] = 1'b0;
        data_s[d]  = ~b;
        run_frame(d, b, par_en, par_bit, len, tag);
        step();
        check({tag, " done single pulse"}, 32'(done_s[d]), 32'd0);
    endtask

    initial begin
        logic [3:0] agg_tx_low;
        logic [3:0] agg_not_ready;
        logic [3:0] agg_busy;
        logic [3:0] agg_done;
        logic       any_done;
        logic       any_low;

        vecs[0] = '{dut: 0, data: 8'hA5, par_en: 1'b0, par_bit: 1'b0, len: 80};
        vecs[1] = '{dut: 0, data: 8'h3C, par_en: 1'b0, par_bit: 1'b0, len: 80};
        vecs[2] = '{dut: 1, data: 8'h03, par_en: 1'b1, par_bit: 1'b0, len: 88};
        vecs[3] = '{dut: 2, data: 8'h03, par_en: 1'b1, par_bit: 1'b1, len: 88};
        vecs[4] = '{dut: 3, data: 8'h03, par_en: 1'b1, par_bit: 1'b0, len: 96};
        vecs[5] = '{dut: 1, data: 8'h80, par_en: 1'b1, par_bit: 1'b1, len: 88};
        vecs[6] = '{dut: 2, data: 8'hFF, par_en: 1'b1, par_bit: 1'b1, len: 88};
        vecs[7] = '{dut: 3, data: 8'h07, par_en: 1'b1, par_bit: 1'b1, len: 96};

        rst_n   = 1'b0;
        valid_s = 4'h0;
        for (int i = 0; i < 4; i++) data_s[i] = 8'h00;
        repeat (3) step();
        check("reset tx high", 32'(tx_s), 32'hF);
        check("reset ready low", 32'(ready_s), 32'h0);
        rst_n = 1'b1;
        step();

        // Idle for 50 cycles.
        agg_tx_low    = 4'h0;
        agg_not_ready = 4'h0;
        agg_busy      = 4'h0;
        agg_done      = 4'h0;
        for (int k = 0; k < 50; k++) begin
            agg_tx_low    = agg_tx_low | ~tx_s;
            agg_not_ready = agg_not_ready | ~ready_s;
            agg_busy      = agg_busy | busy_s;
            agg_done      = agg_done | done_s;
            step();
        end
        check("idle tx high", 32'(agg_tx_low), 32'h0);
        check("idle ready", 32'(agg_not_ready), 32'h0);
        check("idle busy low", 32'(agg_busy), 32'h0);
        check("idle no done", 32'(agg_done), 32'h0);

        // Table of single frames.
        for (int v = 0; v < 8; v++) begin
            send(vecs[v].dut, vecs[v].data, vecs[v].par_en, vecs[v].par_bit,
                 vecs[v].len, $sformatf("vec%0d", v));
        end

        // Back-to-back with tx_valid held: 0x55 then 0xFF. tx_data changes to
        // 0xFF during the first frame; the first frame must still carry 0x55.
        valid_s[0] = 1'b1;
        data_s[0]  = 8'h55;
        step();
        data_s[0]  = 8'hFF;
        run_frame(0, 8'h55, 1'b0, 1'b0, 80, "b2b first");
        // One ready cycle, then the second start bit: 81 cycles after the first.
        step();
        check("b2b second start low", 32'(tx_s[0]), 32'd0);
        check("b2b ready one cycle only", 32'(ready_s[0]), 32'd0);
        check("b2b busy again", 32'(busy_s[0]), 32'd1);
        check("b2b done dropped", 32'(done_s[0]), 32'd0);
        valid_s[0] = 1'b0;
        data_s[0]  = 8'h00;
        run_frame(0, 8'hFF, 1'b0, 1'b0, 80, "b2b second");
        step();

        // Reset at cycle 30 of a frame.
        valid_s[0] = 1'b1;
        data_s[0]  = 8'h3C;
        step();
        valid_s[0] = 1'b0;
        repeat (30) step();
        check("pre-reset busy", 32'(busy_s[0]), 32'd1);
        rst_n      = 1'b0;
        valid_s[0] = 1'b1;
        step();
        check("mid reset tx high", 32'(tx_s[0]), 32'd1);
        check("mid reset busy low", 32'(busy_s[0]), 32'd0);
        check("mid reset no done", 32'(done_s[0]), 32'd0);
        check("mid reset ready low", 32'(ready_s[0]), 32'd0);
        step();
        rst_n      = 1'b1;
        valid_s[0] = 1'b0;
        step();
        check("post reset ready", 32'(ready_s[0]), 32'd1);
        check("post reset not busy", 32'(busy_s[0]), 32'd0);
        any_done = 1'b0;
        any_low  = 1'b0;
        for (int k = 0; k < 100; k++) begin
            any_done = any_done | done_s[0];
            any_low  = any_low | ~tx_s[0];
            step();
        end
        check("abandoned frame no done", 32'(any_done), 32'd0);
        check("abandoned frame line idle", 32'(any_low), 32'd0);
        send(0, 8'hC3, 1'b0, 1'b0, 80, "after reset");

        // A few random bytes through the plain 8-N-1 instance.
        for (int r = 0; r < 3; r++) begin
            send(0, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 80, $sformatf("rand%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
